// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined Vedic multiplier: operand magnitudes, Vedic partial
// products, then recombination and sign restore (registered or not via OUT_REG).

module vedic_mul_core #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  if (W == 2) begin : g_base
    logic pp00, pp10, pp01, pp11, c1;
    assign pp00 = a_i[0] & b_i[0];
    assign pp10 = a_i[1] & b_i[0];
    assign pp01 = a_i[0] & b_i[1];
    assign pp11 = a_i[1] & b_i[1];
    assign c1   = pp10 & pp01;
    assign p_o  = {pp11 & c1, pp11 ^ c1, pp10 ^ pp01, pp00};
  end else begin : g_rec
    localparam int H = W / 2;
    logic [W-1:0] ll, hl, lh, hh;
    logic [W:0]   mid;

    vedic_mul_core #(.W(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
    vedic_mul_core #(.W(H)) u_hl (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
    vedic_mul_core #(.W(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(lh));
    vedic_mul_core #(.W(H)) u_hh (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(hh));

    // Cross terms can carry one bit past W, so the middle sum is W+1 wide.
    assign mid = {1'b0, hl} + {1'b0, lh};
    assign p_o = {{W{1'b0}}, ll} + ({{(W-1){1'b0}}, mid} << H) + {hh, {W{1'b0}}};
  end
endmodule

module vedic_mul_pipe #(
  parameter int WIDTH   = 8,
  parameter bit OUT_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int H = WIDTH / 2;

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // whole pipeline moves as one (advance) and freezes while the output stalls.
  logic advance;
  logic s3_v;

  logic             s1_v_q, s1_neg_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [WIDTH-1:0] mag_a_d, mag_b_d;
  logic             neg_d;

  logic             s2_v_q, s2_neg_q;
  logic [WIDTH-1:0] s2_ll_q, s2_hl_q, s2_lh_q, s2_hh_q;
  logic [WIDTH-1:0] ll_d, hl_d, lh_d, hh_d;

  logic [2*WIDTH-1:0] sum_d, res_d;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign busy     = s1_v_q | s2_v_q | s3_v;

  // Negating the most-negative value yields 2^(WIDTH-1), which fits unsigned.
  always_comb begin
    mag_a_d = a;
    mag_b_d = b;
    neg_d   = 1'b0;
    if (signed_mode) begin
      if (a[WIDTH-1]) mag_a_d = -a;
      if (b[WIDTH-1]) mag_b_d = -b;
      neg_d = a[WIDTH-1] ^ b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_neg_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
    end else if (advance) begin
      s1_v_q   <= in_valid;
      s1_neg_q <= neg_d;
      s1_a_q   <= mag_a_d;
      s1_b_q   <= mag_b_d;
    end
  end

  vedic_mul_core #(.W(H)) u_pp_ll (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[H-1:0]),     .p_o(ll_d));
  vedic_mul_core #(.W(H)) u_pp_hl (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[H-1:0]),     .p_o(hl_d));
  vedic_mul_core #(.W(H)) u_pp_lh (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[WIDTH-1:H]), .p_o(lh_d));
  vedic_mul_core #(.W(H)) u_pp_hh (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[WIDTH-1:H]), .p_o(hh_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q   <= 1'b0;
      s2_neg_q <= 1'b0;
      s2_ll_q  <= '0;
      s2_hl_q  <= '0;
      s2_lh_q  <= '0;
      s2_hh_q  <= '0;
    end else if (advance) begin
      s2_v_q   <= s1_v_q;
      s2_neg_q <= s1_neg_q;
      s2_ll_q  <= ll_d;
      s2_hl_q  <= hl_d;
      s2_lh_q  <= lh_d;
      s2_hh_q  <= hh_d;
    end
  end

  always_comb begin
    sum_d = {{WIDTH{1'b0}}, s2_ll_q}
          + (({{WIDTH{1'b0}}, s2_hl_q} + {{WIDTH{1'b0}}, s2_lh_q}) << H)
          + {s2_hh_q, {WIDTH{1'b0}}};
    res_d = s2_neg_q ? -sum_d : sum_d;
  end

  if (OUT_REG) begin : g_out_reg
    logic               s3_v_q;
    logic [2*WIDTH-1:0] p_q;

    // Bubbles load zero so p reads 0 whenever out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s3_v_q <= 1'b0;
        p_q    <= '0;
      end else if (advance) begin
        s3_v_q <= s2_v_q;
        p_q    <= s2_v_q ? res_d : '0;
      end
    end

    assign s3_v      = s3_v_q;
    assign out_valid = s3_v_q;
    assign p         = p_q;
  end else begin : g_out_comb
    assign s3_v      = 1'b0;
    assign out_valid = s2_v_q;
    assign p         = res_d;
  end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed bench for vedic_mul_pipe: 8-bit registered-output instance plus
// 16-bit (OUT_REG=0) and 32-bit instances swept against a behavioural product.

module tb_vedic_mul_pipe;
  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        in_valid16, in_ready16, sm16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic        in_valid32, in_ready32, sm32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  logic [15:0] exp_q[$];
  logic [31:0] exp16_q[$];
  logic [63:0] exp32_q[$];

  logic [15:0] c16[4];
  logic [31:0] c32[4];

  int checks = 0;
  int errors = 0;

  vedic_mul_pipe #(.WIDTH(8), .OUT_REG(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .busy(busy)
  );

  vedic_mul_pipe #(.WIDTH(16), .OUT_REG(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .signed_mode(sm16), .out_valid(out_valid16),
    .out_ready(out_ready16), .p(p16), .busy(busy16)
  );

  vedic_mul_pipe #(.WIDTH(32), .OUT_REG(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .signed_mode(sm32), .out_valid(out_valid32),
    .out_ready(out_ready32), .p(p32), .busy(busy32)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic sm);
    logic signed [31:0] sx, sy;
    if (sm) begin
      sx = $signed(x);
      sy = $signed(y);
      return 32'(sx * sy);
    end
    return {16'b0, x} * {16'b0, y};
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic sm);
    logic signed [63:0] sx, sy;
    if (sm) begin
      sx = $signed(x);
      sy = $signed(y);
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Driver: called at posedge+2, returns at posedge+2 after the accept edge.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                      input logic [15:0] ev);
    int n = 0;
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(in_ready), 64'd1);
    exp_q.push_back(ev);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain8();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain8", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  // Scoreboards: compare each retired product with the head of its queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("p8_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("p8", 64'(p), 64'(exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid16 && out_ready16) begin
      chk("p16_pending", 64'(exp16_q.size() != 0), 64'd1);
      if (exp16_q.size() != 0) chk("p16", 64'(p16), 64'(exp16_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid32 && out_ready32) begin
      chk("p32_pending", 64'(exp32_q.size() != 0), 64'd1);
      if (exp32_q.size() != 0) chk("p32", p32, exp32_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sm16 = 1'b0; out_ready16 = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; sm32 = 1'b0; out_ready32 = 1'b1;
    c16 = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000};
    c32 = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};

    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Unsigned 0xFF*0xFF, accepted on the first edge after reset, latency 3
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    @(negedge clk); chk("lat_c1_valid", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_c2_valid", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_c3_valid", 64'(out_valid), 64'd1);
    chk("lat_c3_p", 64'(p), 64'hFE01);
    @(posedge clk); #2;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_p_zero", 64'(p), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #2;

    // Signed corners back-to-back with an unsigned one
    send(8'h80, 8'h80, 1'b1, 16'h4000);
    send(8'hFF, 8'h7F, 1'b1, 16'hFF81);
    send(8'h80, 8'h7F, 1'b1, 16'hC080);
    send(8'h80, 8'h80, 1'b0, 16'h4000);
    wait_drain8();

    // Output stall with four transactions
    out_ready = 1'b0;
    send(8'h03, 8'h05, 1'b0, 16'h000F);
    send(8'h12, 8'h34, 1'b0, 16'h03A8);
    send(8'hFE, 8'h03, 1'b1, 16'hFFFA);
    a = 8'h0F; b = 8'hF0; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("stall_valid_rise", 64'(out_valid), 64'd1);
    chk("stall_in_ready_drop", 64'(in_ready), 64'd0);
    chk("stall_p", 64'(p), 64'h000F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold_ready", 64'(in_ready), 64'd0);
      chk("stall_hold_p", 64'(p), 64'h000F);
      chk("stall_hold_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(8'h0F, 8'hF0, 1'b0, 16'h0E10);
    wait_drain8();

    // Reset with three transactions in flight
    send(8'h07, 8'h09, 1'b0, 16'h003F);
    send(8'h10, 8'h10, 1'b0, 16'h0100);
    send(8'h81, 8'h02, 1'b1, 16'hFF02);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_p", 64'(p), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_busy", 64'(busy), 64'd0);
    @(posedge clk); #2;
    send(8'h03, 8'h05, 1'b0, 16'h000F);
    wait_drain8();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #2;

    // 16-bit combinational output: latency 2
    a16 = 16'hFFFF; b16 = 16'hFFFF; sm16 = 1'b0; in_valid16 = 1'b1;
    exp16_q.push_back(32'hFFFE_0001);
    @(posedge clk); #2;
    in_valid16 = 1'b0;
    @(negedge clk); chk("lat16_c1_valid", 64'(out_valid16), 64'd0);
    @(negedge clk); chk("lat16_c2_valid", 64'(out_valid16), 64'd1);
    chk("lat16_c2_p", 64'(p16), 64'hFFFE_0001);
    @(posedge clk); #2;

    // Wide sweep: corner pairs in both modes, then random operands
    for (int i = 0; i < 10032; i++) begin
      if (i < 32) begin
        a16 = c16[(i % 16) % 4]; b16 = c16[(i % 16) / 4]; sm16 = (i >= 16);
        a32 = c32[(i % 16) % 4]; b32 = c32[(i % 16) / 4]; sm32 = (i >= 16);
      end else begin
        a16 = 16'($urandom_range(0, 16'hFFFF));
        b16 = 16'($urandom_range(0, 16'hFFFF));
        sm16 = 1'($urandom_range(0, 1));
        a32 = $urandom();
        b32 = $urandom();
        sm32 = 1'($urandom_range(0, 1));
      end
      in_valid16 = 1'b1;
      in_valid32 = 1'b1;
      exp16_q.push_back(ref16(a16, b16, sm16));
      exp32_q.push_back(ref32(a32, b32, sm32));
      @(posedge clk); #2;
    end
    in_valid16 = 1'b0;
    in_valid32 = 1'b0;
    for (int n = 0; n < 30 && (exp16_q.size() != 0 || exp32_q.size() != 0); n++)
      @(negedge clk);
    chk("drain16", 64'(exp16_q.size()), 64'd0);
    chk("drain32", 64'(exp32_q.size()), 64'd0);
    @(negedge clk);
    chk("idle32_p_zero", p32, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vedic_mul_pipe.md
VEDIC_MUL_PIPE -- requirements
Module: vedic_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; legal values 4, 8, 16, 32.
REQ-002 SHALL have parameter OUT_REG, default 1; 1 = registered output stage, 0 = output taken directly from the sum stage.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand pair presented.
REQ-006 SHALL have port in_ready, output, 1, pipeline accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH, multiplicand.
REQ-008 SHALL have port b, input, WIDTH, multiplier.
REQ-009 SHALL have port signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with a/b.
REQ-010 SHALL have port out_valid, output, 1, product available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-012 SHALL have port p, output, 2*WIDTH, product.
REQ-013 SHALL have port busy, output, 1, any pipeline stage holds a valid entry.

Function
REQ-014 SHALL accept a transaction on a cycle with in_valid && in_ready.
REQ-015 SHALL retire a transaction on a cycle with out_valid && out_ready.
REQ-016 Stage S1 SHALL register operand magnitudes (|a|, |b| in signed mode; raw a, b in unsigned mode) plus a result-sign bit = a[MSB]^b[MSB] in signed mode, else 0.
REQ-017 Stage S2 SHALL register four WIDTH/2 x WIDTH/2 partial products (lo*lo, hi*lo, lo*hi, hi*hi), each built by recursive Vedic decomposition down to 2x2 units.
REQ-018 Stage S3 SHALL compute ll + ((hl + lh) << WIDTH/2) + (hh << WIDTH) at full 2*WIDTH width, then negate if the sign bit is set.
REQ-019 S3 SHALL be registered when OUT_REG=1 (latency 3 cycles accept->out_valid) and combinational when OUT_REG=0 (latency 2).
REQ-020 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1) held as unsigned WIDTH bits, with no overflow.
REQ-021 p SHALL equal the exact 2*WIDTH-bit product: two's-complement in signed mode, unsigned otherwise; no truncation.
REQ-022 Pipeline advance SHALL be global: advance = !out_valid || out_ready.
REQ-023 in_ready SHALL equal advance.
REQ-024 All stages SHALL hold contents and valid bits while advance=0.
REQ-025 p SHALL be stable while out_valid && !out_ready.
REQ-026 Throughput SHALL be one transaction per cycle when out_ready stays high.
REQ-027 Empty stages (valid bit 0) SHALL advance as bubbles; data in bubble stages is don't-care, but p SHALL be 0 when out_valid=0 with OUT_REG=1.
REQ-028 Accept and retire in the same cycle SHALL both occur with no loss or duplication.
REQ-029 busy SHALL be the OR of all stage valid bits.
REQ-030 signed_mode SHALL be carried per transaction, so mixed-mode back-to-back transactions are each computed correctly.

Reset
REQ-031 While rst_n=0, all stage valid bits, out_valid, busy and p SHALL be 0, asynchronously.
REQ-032 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-033 Reset mid-operation SHALL discard all in-flight transactions; no product from before reset SHALL appear after reset.
REQ-034 The first accept SHALL be allowed in the first rising edge with rst_n=1.

Verification
REQ-035 WIDTH=8, unsigned, a=0xFF, b=0xFF, out_ready=1 -> p=0xFE01 with out_valid exactly 3 cycles after accept (OUT_REG=1).
REQ-036 WIDTH=8, signed: -128*-128 -> 0x4000; -1*127 -> 0xFF81; -128*127 -> 0xC080; issued back-to-back with an unsigned 0x80*0x80 -> 0x4000; all in order on consecutive cycles.
REQ-037 Hold out_ready=0 for 5 cycles with 4 transactions issued -> in_ready drops the cycle out_valid rises; p stays constant; on release, all 4 products emerge in order with none lost or duplicated.
REQ-038 Assert rst_n=0 mid-cycle with 3 transactions in flight -> out_valid, busy and p go 0 immediately; after release, no stale product appears and a new 3*5 yields 15.
REQ-039 WIDTH=16 and 32, random signed/unsigned operands (at least 10k each, including 0, 1, all-ones and most-negative) -> every p matches a behavioural reference; also run OUT_REG=0 with latency 2.
